// File: rtl/led_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : led_seq_pkg
//  Brief    : Mode encoding and per-mode initial LED patterns for led_pattern_seq
//  Revision : 1.0  initial release
// ============================================================================
package led_seq_pkg;

    typedef enum logic [1:0] {
        COUNT  = 2'd0,
        SHIFT  = 2'd1,
        BOUNCE = 2'd2,
        BLINK  = 2'd3
    } mode_e;

    localparam logic [3:0] c_init_count  = 4'b0000;
    localparam logic [3:0] c_init_shift  = 4'b0001;
    localparam logic [3:0] c_init_bounce = 4'b0001;
    localparam logic [3:0] c_init_blink  = 4'b0000;

    function automatic logic [3:0] init_pattern(input mode_e m);
        logic [3:0] v;
        case (m)
            COUNT:   v = c_init_count;
            SHIFT:   v = c_init_shift;
            BOUNCE:  v = c_init_bounce;
            BLINK:   v = c_init_blink;
            default: v = c_init_count;
        endcase
        return v;
    endfunction

    function automatic mode_e next_mode(input mode_e m);
        mode_e n;
        case (m)
            COUNT:   n = SHIFT;
            SHIFT:   n = BOUNCE;
            BOUNCE:  n = BLINK;
            BLINK:   n = COUNT;
            default: n = COUNT;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce
//  Brief    : 2-flop synchronizer, counter debouncer and registered press pulse
//  Revision : 1.0  initial release
// ============================================================================
module btn_debounce #(
    parameter int DB_CYCLES = 270_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] c_cnt_last = CW'(DB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_level_d;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= btn_raw;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            // Registered edge detect keeps press glitch-free for the mode FSM
            r_press   <= r_level & ~r_level_d;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_cnt   <= '0;
                r_level <= ~r_level;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/led_pattern_seq.sv
`default_nettype none
// ============================================================================
//  Module   : led_pattern_seq
//  Brief    : Button-selected 4-LED pattern sequencer (count/shift/bounce/blink)
//  Revision : 1.0  initial release
// ============================================================================
module led_pattern_seq
    import led_seq_pkg::*;
#(
    parameter int STEP_CYCLES = 6_750_000,
    parameter int DB_CYCLES   = 270_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    output logic [3:0] pattern,
    output logic [1:0] mode,
    output logic       step
);

    localparam int PW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [PW-1:0] c_presc_last = PW'(STEP_CYCLES - 1);

    mode_e         r_mode;
    mode_e         w_mode_next;
    logic [3:0]    r_pattern;
    logic [3:0]    w_pattern_next;
    logic          r_dir_up;
    logic          w_dir_next;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_next;
    logic          w_step;
    logic          w_press;
    logic          w_unused_level;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_btn_debounce (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn),
        .level   (w_unused_level),
        .press   (w_press)
    );

    assign w_step = (r_presc == c_presc_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode    <= COUNT;
            r_pattern <= 4'b0000;
            r_dir_up  <= 1'b1;
            r_presc   <= '0;
        end else begin
            r_mode    <= w_mode_next;
            r_pattern <= w_pattern_next;
            r_dir_up  <= w_dir_next;
            r_presc   <= w_presc_next;
        end
    end

    // A press overrides any coincident step: the new mode starts from its initial value
    always_comb begin
        w_mode_next    = r_mode;
        w_pattern_next = r_pattern;
        w_dir_next     = r_dir_up;
        w_presc_next   = w_step ? '0 : r_presc + 1'b1;
        if (w_press) begin
            w_mode_next    = next_mode(r_mode);
            w_pattern_next = init_pattern(w_mode_next);
            w_dir_next     = 1'b1;
            w_presc_next   = '0;
        end else if (w_step) begin
            case (r_mode)
                COUNT:  w_pattern_next = r_pattern + 4'd1;
                SHIFT:  w_pattern_next = {r_pattern[2:0], r_pattern[3]};
                BOUNCE: begin
                    if (r_dir_up) begin
                        if (r_pattern[3]) begin
                            w_dir_next     = 1'b0;
                            w_pattern_next = 4'b0100;
                        end else begin
                            w_pattern_next = r_pattern << 1;
                        end
                    end else begin
                        if (r_pattern[0]) begin
                            w_dir_next     = 1'b1;
                            w_pattern_next = 4'b0010;
                        end else begin
                            w_pattern_next = r_pattern >> 1;
                        end
                    end
                end
                BLINK:   w_pattern_next = ~r_pattern;
                default: w_pattern_next = r_pattern;
            endcase
        end
    end

    assign pattern = r_pattern;
    assign mode    = r_mode;
    assign step    = w_step;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_pattern_seq
//  Brief    : Directed + random bench for led_pattern_seq against a step-phase model
//  Revision : 1.0  initial release
// ============================================================================
module tb_led_pattern_seq;

    localparam int STEP = 4;
    localparam int DB   = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic [3:0] pattern;
    logic [1:0] mode;
    logic       step;

    int checks = 0;
    int errors = 0;

    // Model: mode, steps taken since mode entry, cycles into the step interval,
    // accepted button level and length of the current disagreeing raw run.
    int m_mode, m_phase, m_presc, m_acc, m_run, edge_n;
    int press_at[$];
    logic [3:0] bounce_tab [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010};

    led_pattern_seq #(
        .STEP_CYCLES (STEP),
        .DB_CYCLES   (DB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn     (btn),
        .pattern (pattern),
        .mode    (mode),
        .step    (step)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] exp_pattern();
        case (m_mode)
            0:       return 4'(m_phase % 16);
            1:       return 4'(1 << (m_phase % 4));
            2:       return bounce_tab[m_phase % 6];
            default: return (m_phase % 2 == 1) ? 4'hF : 4'h0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s edge %0d: observed %0h expected %0h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic tick();
        bit press_now;
        bit step_now;
        @(posedge clk);
        edge_n++;
        if (rst) begin
            m_mode  = 0;
            m_phase = 0;
            m_presc = 0;
            m_acc   = 0;
            m_run   = 0;
            press_at.delete();
        end else begin
            press_now = (press_at.size() > 0) && (press_at[0] == edge_n);
            if (press_now) void'(press_at.pop_front());
            step_now = (m_presc == STEP - 1);
            if (press_now) begin
                m_mode  = (m_mode + 1) % 4;
                m_phase = 0;
                m_presc = 0;
            end else if (step_now) begin
                m_phase++;
                m_presc = 0;
            end else begin
                m_presc++;
            end
            // DB agreeing raw samples accept a level; the mode reacts 4 edges later
            if (int'(btn) != m_acc) begin
                m_run++;
                if (m_run == DB) begin
                    m_acc = int'(btn);
                    m_run = 0;
                    if (btn) press_at.push_back(edge_n + 4);
                end
            end else begin
                m_run = 0;
            end
        end
        #1;
        check("mode", {2'b00, mode}, 4'(m_mode));
        check("pattern", pattern, exp_pattern());
        check("step", {3'b000, step}, {3'b000, (m_presc == STEP - 1)});
    endtask

    task automatic press_hold(input int hi, input int lo);
        btn = 1'b1;
        repeat (hi) tick();
        btn = 1'b0;
        repeat (lo) tick();
    endtask

    initial begin
        edge_n = 0;
        rst = 1'b1;
        btn = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Idle COUNT run long enough to observe the F->0 wrap
        repeat (70) tick();

        // Short glitches must not register
        for (int i = 0; i < 3; i++) begin
            btn = 1'b1;
            repeat (2) tick();
            btn = 1'b0;
            repeat (2) tick();
        end
        repeat (8) tick();

        // SHIFT, then BOUNCE, then BLINK
        press_hold(10, 20);
        press_hold(10, 30);
        press_hold(10, 12);

        // Align the press so the mode change lands on a step cycle
        for (int i = 0; i < 8 && m_presc != 1; i++) tick();
        press_hold(10, 12);

        // Random button activity
        for (int seg = 0; seg < 60; seg++) begin
            btn = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 8)) tick();
        end
        btn = 1'b0;
        repeat (8) tick();

        // Reach BOUNCE, then reset mid-debounce with the button held
        for (int i = 0; i < 6 && m_mode != 2; i++) press_hold(8, 8);
        check("reached_bounce", 4'(m_mode), 4'd2);
        repeat (5) tick();
        btn = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (25) tick();
        check("held_one_press", 4'(m_mode), 4'd1);
        btn = 1'b0;
        repeat (8) tick();

        // Random button activity with occasional resets
        for (int seg = 0; seg < 60; seg++) begin
            btn = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 8)) begin
                rst = ($urandom_range(0, 39) == 0);
                tick();
            end
        end
        rst = 1'b0;
        btn = 1'b0;
        repeat (10) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_pattern_seq.md
LED_PATTERN_SEQ -- requirements
Module: led_pattern_seq

Interface
REQ-001 Parameter STEP_CYCLES, default 6_750_000, clock cycles per pattern step (4 Hz at 27 MHz); legal range >= 2.
REQ-002 Parameter DB_CYCLES, default 270_000, consecutive stable cycles required to accept a button level (10 ms at 27 MHz); legal range >= 2.
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 btn  input  1  raw asynchronous push-button, active-high (pressed = 1).
REQ-006 pattern  output  4  active-high LED pattern; it feeds the downstream 4-bit inverter that drives the active-low board LEDs.
REQ-007 mode  output  2  current mode encoding.
REQ-008 step  output  1  one-cycle pulse marking each pattern advance.

Function
REQ-009 btn SHALL pass through a 2-flop synchronizer before any other use.
REQ-010 Debounce SHALL behave as follows:
- A counter increments while the synchronized level differs from the debounced state.
- The counter clears on any cycle where the two levels are equal.
- The debounced state flips on the edge where the counter would reach DB_CYCLES.
REQ-011 press SHALL be a one-cycle internal pulse on a 0->1 transition of the debounced state; releases SHALL generate nothing.
REQ-012 The mode FSM SHALL cycle COUNT(0) -> SHIFT(1) -> BOUNCE(2) -> BLINK(3) -> COUNT on each press.
REQ-013 mode SHALL change exactly DB_CYCLES+3 rising edges after the first edge that samples btn=1 with btn held steady.
REQ-014 The prescaler SHALL count 0..STEP_CYCLES-1 and wrap, asserting step for one cycle at the wrap.
REQ-015 On step, pattern SHALL advance per the current mode:
- COUNT: +1 modulo 16; F wraps to 0.
- SHIFT: rotate left 0001->0010->0100->1000->0001.
- BOUNCE: 0001->0010->0100->1000->0100->0010->0001 ..., with the direction flag reversing at 1000 and at 0001.
- BLINK: toggle 0000 <-> 1111.
REQ-016 On press, pattern SHALL load the new mode's initial value on the same edge as the mode change: COUNT 0000, SHIFT 0001, BOUNCE 0001 with direction up, BLINK 0000.
REQ-017 On press, the prescaler SHALL clear to 0 on the same edge as the mode change.
REQ-018 If press and step coincide, press SHALL win: initial value loaded, no advance applied, step still asserted that cycle.
REQ-019 Bounce shorter than DB_CYCLES cycles SHALL produce no press and no mode change.
REQ-020 A button held indefinitely SHALL produce exactly one press.
REQ-021 SHIFT and BOUNCE patterns SHALL always be one-hot, and no reachable state SHALL output 0000 in those modes.

Reset
REQ-022 On rst=1 at a rising edge, the following SHALL take effect at that edge:
- mode=COUNT, pattern=0000, step=0
- prescaler=0, debounce counter=0
- synchronizer flops=0, debounced state=0
- direction=up
REQ-023 Reset SHALL take priority over press and step, including in the middle of a debounce or a step interval.
REQ-024 A button already held when rst deasserts SHALL be treated as a new press (debounced state restarts at 0), yielding one mode change DB_CYCLES+3 edges later.

Structure
REQ-025 Package led_seq_pkg SHALL hold:
- the mode_e enum (COUNT, SHIFT, BOUNCE, BLINK; 2-bit)
- the 4-bit initial-pattern constants per mode.
REQ-026 Synchronizer, debounce and rising-edge detection SHALL live in sub-module btn_debounce (ports: clk, rst, btn_raw, level, press; parameter DB_CYCLES).
REQ-027 Prescaler, mode FSM and pattern update SHALL reside in led_pattern_seq.

Verification (STEP_CYCLES=4, DB_CYCLES=3)
REQ-028 Reset then btn=0 for 70 cycles -> mode=0; step every 4th cycle; pattern 0,1,...,F,0 (wrap observed).
REQ-029 btn pulses 1 for 2 cycles, three times, separated by 2 low cycles -> no mode change, COUNT sequence undisturbed.
REQ-030 One clean press (held 10 cycles) -> mode=1 exactly 6 edges after first sampled high, pattern=0001 that edge, then 0010, 0100, 1000, 0001 on successive steps.
REQ-031 A second press enters BOUNCE -> pattern 0001,0010,0100,1000,0100,0010,0001,0010. A third press enters BLINK -> 0000,1111,0000.
REQ-032 Press timed so that the mode change coincides with step -> pattern equals the new mode's initial value, not advanced; the next step comes 4 cycles later.
REQ-033 Assert rst for 1 cycle mid-BOUNCE with btn held high -> all outputs at reset values. After deassert -> exactly one press, mode=1 six edges later.
